// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: processes SLICE bits per clock, LSB first,
// and presents a full-width result with carry and signed overflow.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned SW     = SLICE + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             accept_c;
  logic             last_c;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sub_q;
  logic             carry_q;
  logic [SLICE-1:0] b_sl_c;
  logic [SLICE:0]   slice_c;
  logic             ovf_c;

  // Operands shift right each RUN cycle, so the active slice is always at bit 0.
  assign last_c  = (cnt_q == CNT_W'(NSLICE - 1));
  assign b_sl_c  = sub_q ? ~b_q[SLICE-1:0] : b_q[SLICE-1:0];
  assign slice_c = SW'(a_q[SLICE-1:0]) + SW'(b_sl_c) + SW'(carry_q);
  // Carry-in XOR carry-out of the MSB, expressed via operand/result sign bits.
  assign ovf_c   = (a_q[SLICE-1] == b_sl_c[SLICE-1]) && (slice_c[SLICE-1] != a_q[SLICE-1]);

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        if (last_c) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
    end
  end

  // Operand capture and slice-serial datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept_c) begin
      a_q     <= a;
      b_q     <= b;
      sub_q   <= sub;
      carry_q <= sub ? ~c_in : c_in;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> SLICE;
      b_q     <= b_q >> SLICE;
      carry_q <= slice_c[SLICE];
      cnt_q   <= cnt_q + CNT_W'(1);
      sum     <= (sum >> SLICE) | (WIDTH'(slice_c[SLICE-1:0]) << (WIDTH - SLICE));
      if (last_c) begin
        c_out    <= slice_c[SLICE];
        overflow <= ovf_c;
      end
    end
  end

endmodule
